// File: rtl/my_syncmon_if.sv
// Signal bundle between the SYNC monitor and its consumer.
// The master side drives enable and the raw strobe, the slave side (the monitor) returns status.
interface my_syncmon_if;
    logic        EN;
    logic        SYNC_IN;
    logic        SYNC_DET;
    logic        LOCKED;
    logic        ERR_EARLY;
    logic        ERR_MISS;
    logic [27:0] PERIOD;
    logic [7:0]  ERR_CNT;

    modport master (
        output EN,
        output SYNC_IN,
        input  SYNC_DET,
        input  LOCKED,
        input  ERR_EARLY,
        input  ERR_MISS,
        input  PERIOD,
        input  ERR_CNT
    );

    modport slave (
        input  EN,
        input  SYNC_IN,
        output SYNC_DET,
        output LOCKED,
        output ERR_EARLY,
        output ERR_MISS,
        output PERIOD,
        output ERR_CNT
    );
endinterface

// File: rtl/my_syncmon.sv
// Receive-side monitor for the once-per-period SYNC strobe.
// Synchronises SYNC_IN, detects rising edges, and checks each pulse-to-pulse
// interval against the expected period plus or minus a tolerance.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_ACQ    | waiting for the first edge; no interval reference yet
// ST_TRACK  | have a reference, counting good intervals towards lock
// ST_LOCKED | LOCK_CNT consecutive good intervals seen; LOCKED asserted
module my_syncmon #(
    parameter logic [27:0] CNT_1SEC = 28'd199999999,
    parameter logic [27:0] TOL      = 28'd16,
    parameter logic [3:0]  LOCK_CNT = 4'd3
) (
    input  logic         CLK,
    input  logic         RST_N,
    my_syncmon_if.slave  bus
);

    localparam logic [27:0] P_NOM = CNT_1SEC + 28'd1;
    localparam logic [27:0] P_MIN = P_NOM - TOL;
    localparam logic [27:0] P_MAX = P_NOM + TOL;

    localparam logic [1:0] ST_ACQ    = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic        edge_q, edge_d;
    logic [27:0] cnt_q, cnt_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic        det_q, det_d;
    logic        early_q, early_d;
    logic        miss_q, miss_d;
    logic        locked_q, locked_d;
    logic [27:0] period_q, period_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [27:0] interval;
    logic [3:0]  good_inc;

    // Distance in clocks from the previous edge cycle to this one.
    assign interval = cnt_q + 28'd1;
    assign good_inc = good_q + 4'd1;

    // Next-state logic: synchroniser, interval counter, acquisition FSM and error counter.
    always_comb begin
        s1_d      = bus.SYNC_IN;
        s2_d      = s1_q;
        s3_d      = s2_q;
        // Registered edge adds the third clock of latency between first sample and SYNC_DET.
        edge_d    = s2_q & ~s3_q;
        cnt_d     = edge_q ? 28'd0 : ((cnt_q == '1) ? cnt_q : cnt_q + 28'd1);
        state_d   = state_q;
        good_d    = good_q;
        period_d  = period_q;
        det_d     = edge_q;
        early_d   = 1'b0;
        miss_d    = 1'b0;

        case (state_q)
            ST_ACQ: begin
                if (edge_q) begin
                    state_d = ST_TRACK;
                    good_d  = 4'd0;
                end
            end
            ST_TRACK, ST_LOCKED: begin
                // Reaching the late threshold is a miss even if an edge lands in the
                // same cycle; that edge is too late to serve as a new reference.
                if (cnt_q == P_MAX) begin
                    miss_d  = 1'b1;
                    state_d = ST_ACQ;
                    good_d  = 4'd0;
                end else if (edge_q) begin
                    period_d = interval;
                    if (interval < P_MIN) begin
                        early_d = 1'b1;
                        good_d  = 4'd0;
                        state_d = ST_TRACK;
                    end else if (state_q == ST_TRACK) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_CNT) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_ACQ;
                good_d  = 4'd0;
            end
        endcase

        // LOCKED rises one cycle after entering lock but drops together with the error pulse.
        locked_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);

        err_cnt_d = err_cnt_q;
        if ((early_d || miss_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        if (!bus.EN) begin
            s1_d      = 1'b0;
            s2_d      = 1'b0;
            s3_d      = 1'b0;
            edge_d    = 1'b0;
            cnt_d     = 28'd0;
            state_d   = ST_ACQ;
            good_d    = 4'd0;
            det_d     = 1'b0;
            early_d   = 1'b0;
            miss_d    = 1'b0;
            locked_d  = 1'b0;
            period_d  = 28'd0;
            err_cnt_d = 8'd0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            edge_q    <= 1'b0;
            cnt_q     <= 28'd0;
            state_q   <= ST_ACQ;
            good_q    <= 4'd0;
            det_q     <= 1'b0;
            early_q   <= 1'b0;
            miss_q    <= 1'b0;
            locked_q  <= 1'b0;
            period_q  <= 28'd0;
            err_cnt_q <= 8'd0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            edge_q    <= edge_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            good_q    <= good_d;
            det_q     <= det_d;
            early_q   <= early_d;
            miss_q    <= miss_d;
            locked_q  <= locked_d;
            period_q  <= period_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.SYNC_DET  = det_q;
    assign bus.LOCKED    = locked_q;
    assign bus.ERR_EARLY = early_q;
    assign bus.ERR_MISS  = miss_q;
    assign bus.PERIOD    = period_q;
    assign bus.ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_my_syncmon.sv
// Bench for my_syncmon: P=100, TOL=2, LOCK_CNT=3.
// A timestamp-based reference model predicts every output each cycle;
// directed checks cover the headline behaviours with fixed expected values.
module tb_my_syncmon;

    localparam int P   = 100;
    localparam int TOL = 2;
    localparam int LC  = 3;

    localparam int M_ACQ = 0;
    localparam int M_TRK = 1;
    localparam int M_LCK = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    my_syncmon_if bus ();

    my_syncmon #(
        .CNT_1SEC (28'd99),
        .TOL      (28'd2),
        .LOCK_CNT (4'd3)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    int cyc = 0;
    int trace_err = 0;
    bit trace_reported = 1'b0;

    int m_mode, m_last, m_good, m_det_cnt;
    bit hist [5];
    bit e_det, e_early, e_miss, e_locked;
    int e_period, e_errcnt;

    int det_cnt = 0, early_cnt = 0, miss_cnt = 0;
    int last_det_cyc = 0, last_miss_cyc = 0;
    int last_start = 0;

    task automatic model_reset();
        m_mode   = M_ACQ;
        m_last   = 0;
        m_good   = 0;
        for (int k = 0; k < 5; k++) hist[k] = 1'b0;
        e_det    = 1'b0;
        e_early  = 1'b0;
        e_miss   = 1'b0;
        e_locked = 1'b0;
        e_period = 0;
        e_errcnt = 0;
    endtask

    // One clock of the reference: edges are timestamped, intervals are timestamp differences.
    task automatic model_step(input bit en, input bit sin);
        int old_mode;
        int age;
        bit ev;
        old_mode = m_mode;
        e_det    = 1'b0;
        e_early  = 1'b0;
        e_miss   = 1'b0;
        if (!en) begin
            model_reset();
            return;
        end
        for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = sin;
        ev = hist[3] & ~hist[4];
        e_det = ev;
        if (ev) m_det_cnt++;
        if (m_mode == M_ACQ) begin
            if (ev) begin
                m_mode = M_TRK;
                m_last = cyc;
                m_good = 0;
            end
        end else begin
            age = cyc - m_last;
            if (age == P + TOL + 1) begin
                e_miss = 1'b1;
                m_mode = M_ACQ;
                m_good = 0;
            end else if (ev) begin
                e_period = age;
                m_last   = cyc;
                if (age < P - TOL) begin
                    e_early = 1'b1;
                    m_good  = 0;
                    m_mode  = M_TRK;
                end else if (m_mode == M_TRK) begin
                    m_good++;
                    if (m_good == LC) m_mode = M_LCK;
                end
            end
        end
        if ((e_early || e_miss) && e_errcnt < 255) e_errcnt++;
        e_locked = (old_mode == M_LCK) && (m_mode == M_LCK);
    endtask

    task automatic tick(input bit en, input bit sin);
        @(negedge clk);
        bus.EN      = en;
        bus.SYNC_IN = sin;
        @(posedge clk);
        #1;
        cyc++;
        model_step(en, sin);
        if (bus.SYNC_DET === 1'b1) begin
            det_cnt++;
            last_det_cyc = cyc;
        end
        if (bus.ERR_EARLY === 1'b1) early_cnt++;
        if (bus.ERR_MISS === 1'b1) begin
            miss_cnt++;
            last_miss_cyc = cyc;
        end
        if ({bus.SYNC_DET, bus.LOCKED, bus.ERR_EARLY, bus.ERR_MISS} !== {e_det, e_locked, e_early, e_miss}
            || bus.PERIOD !== 28'(e_period) || bus.ERR_CNT !== 8'(e_errcnt)) begin
            trace_err++;
            if (!trace_reported) begin
                trace_reported = 1'b1;
                $display("trace diff at cyc %0d: det/lck/early/miss got %b%b%b%b want %b%b%b%b period got %0d want %0d errcnt got %0d want %0d",
                         cyc, bus.SYNC_DET, bus.LOCKED, bus.ERR_EARLY, bus.ERR_MISS,
                         e_det, e_locked, e_early, e_miss, bus.PERIOD, e_period, bus.ERR_CNT, e_errcnt);
            end
        end
    endtask

    // Start a pulse iv clocks after the previous pulse start, then idle until its effects are visible.
    task automatic send_pulse(input int iv, input int w);
        while (cyc + 1 < last_start + iv) tick(1'b1, 1'b0);
        last_start = cyc + 1;
        repeat (w) tick(1'b1, 1'b1);
        while (cyc < last_start + 4) tick(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        int m0;
        #1;
        checks++;
        if ({bus.SYNC_DET, bus.LOCKED, bus.ERR_EARLY, bus.ERR_MISS, bus.PERIOD, bus.ERR_CNT} !== 40'd0)
            $display("FAIL reset_outputs: got %h, want 0",
                     {bus.SYNC_DET, bus.LOCKED, bus.ERR_EARLY, bus.ERR_MISS, bus.PERIOD, bus.ERR_CNT});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        m0 = miss_cnt;
        repeat (500) tick(1'b1, 1'b0);
        checks++;
        if (miss_cnt - m0 !== 0) $display("FAIL idle_no_miss: got %0d misses, want 0", miss_cnt - m0);
        else passed++;
        checks++;
        if ({bus.SYNC_DET, bus.LOCKED, bus.ERR_EARLY, bus.ERR_MISS, bus.PERIOD, bus.ERR_CNT} !== 40'd0)
            $display("FAIL idle_outputs: got %h, want 0",
                     {bus.SYNC_DET, bus.LOCKED, bus.ERR_EARLY, bus.ERR_MISS, bus.PERIOD, bus.ERR_CNT});
        else passed++;
    endtask

    task automatic test_lock();
        int e0, d0;
        e0 = trace_err;
        d0 = det_cnt;
        send_pulse(1, 1);
        checks++;
        if (last_det_cyc - last_start !== 3)
            $display("FAIL det_latency: got %0d, want 3", last_det_cyc - last_start);
        else passed++;
        send_pulse(P, 1);
        checks++;
        if (bus.PERIOD !== 28'd100) $display("FAIL period_after_2nd: got %0d, want 100", bus.PERIOD);
        else passed++;
        send_pulse(P, 1);
        checks++;
        if (bus.LOCKED !== 1'b0) $display("FAIL locked_after_3rd: got %b, want 0", bus.LOCKED);
        else passed++;
        send_pulse(P, 1);
        checks++;
        if (bus.LOCKED !== 1'b1) $display("FAIL locked_after_4th: got %b, want 1", bus.LOCKED);
        else passed++;
        send_pulse(P, 1);
        checks++;
        if (bus.ERR_CNT !== 8'd0) $display("FAIL lock_errcnt: got %0d, want 0", bus.ERR_CNT);
        else passed++;
        checks++;
        if (det_cnt - d0 !== 5) $display("FAIL lock_det_count: got %0d, want 5", det_cnt - d0);
        else passed++;
        checks++;
        if (trace_err - e0 !== 0) $display("FAIL lock_trace: got %0d diffs, want 0", trace_err - e0);
        else passed++;
    endtask

    task automatic test_tolerance();
        int e0, k0;
        e0 = trace_err;
        send_pulse(98, 1);
        checks++;
        if ({bus.LOCKED, bus.PERIOD} !== {1'b1, 28'd98})
            $display("FAIL tol_98: got locked %b period %0d, want 1 98", bus.LOCKED, bus.PERIOD);
        else passed++;
        send_pulse(102, 1);
        checks++;
        if ({bus.LOCKED, bus.PERIOD} !== {1'b1, 28'd102})
            $display("FAIL tol_102: got locked %b period %0d, want 1 102", bus.LOCKED, bus.PERIOD);
        else passed++;
        k0 = early_cnt;
        send_pulse(97, 1);
        checks++;
        if (early_cnt - k0 !== 1) $display("FAIL early_pulse: got %0d, want 1", early_cnt - k0);
        else passed++;
        checks++;
        if ({bus.LOCKED, bus.ERR_CNT, bus.PERIOD} !== {1'b0, 8'd1, 28'd97})
            $display("FAIL early_state: got locked %b errcnt %0d period %0d, want 0 1 97",
                     bus.LOCKED, bus.ERR_CNT, bus.PERIOD);
        else passed++;
        checks++;
        if (trace_err - e0 !== 0) $display("FAIL tol_trace: got %0d diffs, want 0", trace_err - e0);
        else passed++;
    endtask

    task automatic test_miss();
        int e0, m0;
        e0 = trace_err;
        repeat (3) send_pulse(P, 1);
        checks++;
        if (bus.LOCKED !== 1'b1) $display("FAIL relock_after_early: got %b, want 1", bus.LOCKED);
        else passed++;
        m0 = miss_cnt;
        repeat (150) tick(1'b1, 1'b0);
        checks++;
        if (miss_cnt - m0 !== 1) $display("FAIL miss_once: got %0d, want 1", miss_cnt - m0);
        else passed++;
        checks++;
        if (last_miss_cyc - last_det_cyc !== 103)
            $display("FAIL miss_delay: got %0d, want 103", last_miss_cyc - last_det_cyc);
        else passed++;
        checks++;
        if ({bus.LOCKED, bus.ERR_CNT} !== {1'b0, 8'd2})
            $display("FAIL miss_state: got locked %b errcnt %0d, want 0 2", bus.LOCKED, bus.ERR_CNT);
        else passed++;
        repeat (3) send_pulse(P, 1);
        checks++;
        if (bus.LOCKED !== 1'b0) $display("FAIL resume_3rd: got %b, want 0", bus.LOCKED);
        else passed++;
        send_pulse(P, 1);
        checks++;
        if (bus.LOCKED !== 1'b1) $display("FAIL resume_4th: got %b, want 1", bus.LOCKED);
        else passed++;
        checks++;
        if (trace_err - e0 !== 0) $display("FAIL miss_trace: got %0d diffs, want 0", trace_err - e0);
        else passed++;
    endtask

    task automatic test_wide_en();
        int e0, d0;
        e0 = trace_err;
        d0 = det_cnt;
        repeat (5) send_pulse(P, 10);
        checks++;
        if (det_cnt - d0 !== 5) $display("FAIL wide_det_count: got %0d, want 5", det_cnt - d0);
        else passed++;
        checks++;
        if (bus.LOCKED !== 1'b1) $display("FAIL wide_locked: got %b, want 1", bus.LOCKED);
        else passed++;
        tick(1'b0, 1'b0);
        checks++;
        if ({bus.SYNC_DET, bus.LOCKED, bus.ERR_EARLY, bus.ERR_MISS, bus.PERIOD, bus.ERR_CNT} !== 40'd0)
            $display("FAIL en_clear: got %h, want 0",
                     {bus.SYNC_DET, bus.LOCKED, bus.ERR_EARLY, bus.ERR_MISS, bus.PERIOD, bus.ERR_CNT});
        else passed++;
        tick(1'b1, 1'b0);
        checks++;
        if (trace_err - e0 !== 0) $display("FAIL wide_trace: got %0d diffs, want 0", trace_err - e0);
        else passed++;
    endtask

    task automatic test_random();
        int e0, d0, md0, r, iv, w;
        e0  = trace_err;
        d0  = det_cnt;
        md0 = m_det_cnt;
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       iv = int'($urandom_range(95, 105));
            else if (r < 8)  iv = int'($urandom_range(40, 70));
            else if (r == 8) iv = 103;
            else             iv = int'($urandom_range(104, 180));
            w = int'($urandom_range(1, 6));
            send_pulse(iv, w);
            if ($urandom_range(0, 19) == 0) tick(1'b0, 1'b0);
        end
        checks++;
        if (det_cnt - d0 !== m_det_cnt - md0)
            $display("FAIL random_det_count: got %0d, want %0d", det_cnt - d0, m_det_cnt - md0);
        else passed++;
        checks++;
        if (trace_err - e0 !== 0) $display("FAIL random_trace: got %0d diffs, want 0", trace_err - e0);
        else passed++;
    endtask

    task automatic test_saturation();
        int e0;
        e0 = trace_err;
        send_pulse(1, 1);
        repeat (300) send_pulse(50, 1);
        checks++;
        if ({bus.ERR_CNT, bus.PERIOD} !== {8'hFF, 28'd50})
            $display("FAIL sat_errcnt: got errcnt %0d period %0d, want 255 50", bus.ERR_CNT, bus.PERIOD);
        else passed++;
        repeat (5) send_pulse(50, 1);
        checks++;
        if (bus.ERR_CNT !== 8'hFF) $display("FAIL sat_hold: got %0d, want 255", bus.ERR_CNT);
        else passed++;
        checks++;
        if (trace_err - e0 !== 0) $display("FAIL sat_trace: got %0d diffs, want 0", trace_err - e0);
        else passed++;
        repeat (20) tick(1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.SYNC_DET, bus.LOCKED, bus.ERR_EARLY, bus.ERR_MISS, bus.PERIOD, bus.ERR_CNT} !== 40'd0)
            $display("FAIL async_reset: got %h, want 0",
                     {bus.SYNC_DET, bus.LOCKED, bus.ERR_EARLY, bus.ERR_MISS, bus.PERIOD, bus.ERR_CNT});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.EN      = 1'b0;
        bus.SYNC_IN = 1'b0;
        m_det_cnt   = 0;
        model_reset();
        repeat (3) @(posedge clk);
        test_reset();
        test_lock();
        test_tolerance();
        test_miss();
        test_wide_en();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
